div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Sequencer for the iterative divider serving DIV/DIVU in EXE. It stalls the front of the pipeline while the divide runs and delivers HI/LO results.

Interface
REQ-001 Parameter ZERO_FAST, default 1, meaning: 1 = divisor-zero requests complete without iterating; 0 = run the full 32 iterations.
REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 EXE_DivReq  in  1  EXE holds a valid DIV/DIVU.
REQ-005 EXE_DivSigned  in  1  1 = DIV (signed), 0 = DIVU.
REQ-006 EXE_BusA  in  32  dividend, forwarded value.
REQ-007 EXE_BusB  in  32  divisor, forwarded value.
REQ-008 Flush  in  1  abort from exception/ERET commit in MEM.
REQ-009 Div_Stall  out  1  hold PC, IF/ID, ID/EXE; bubble EXE/MEM.
REQ-010 Div_Done  out  1  one-cycle pulse, results valid, EXE may advance.
REQ-011 Div_Lo  out  32  quotient, to LO write path.
REQ-012 Div_Hi  out  32  remainder, to HI write path.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, with a 5-bit iteration counter.
REQ-014 IDLE: on EXE_DivReq=1 and Flush=0, the block SHALL perform the following actions:
  - latch |A|, |B|, the quotient sign (A[31]^B[31] when signed) and the remainder sign (A[31] when signed);
  - clear the counter;
  - go to BUSY, or to DONE when ZERO_FAST=1 and EXE_BusB==0.
REQ-015 Operands SHALL be sampled only in the request cycle; input changes during BUSY are ignored.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle, with counter 0..31, and go to DONE after the step at counter==31.
REQ-017 DONE SHALL assert Div_Done, register the sign-corrected results into Div_Lo/Div_Hi, and go to IDLE unconditionally.
REQ-018 Div_Stall SHALL be combinational, and equal to:
  - 1 in BUSY when Flush=0;
  - 1 in IDLE when EXE_DivReq=1 and Flush=0;
  - 0 otherwise, including all of DONE.
REQ-019 Latency for a nonzero divisor, with the request first seen at cycle T:
  - Div_Stall SHALL be high for cycles T..T+32 (33 cycles);
  - Div_Done SHALL be high at T+33.
REQ-020 Sign correction SHALL be as follows:
  - quotient is negated when the quotient sign is 1;
  - remainder is negated when the remainder sign is 1;
  - all arithmetic is 32-bit modulo.
REQ-021 0x80000000 / 0xFFFFFFFF (signed) SHALL yield Lo=0x80000000, Hi=0x00000000, with no exception.
REQ-022 Divisor==0, either parameter setting, SHALL yield Lo=0xFFFFFFFF and Hi=latched original EXE_BusA.
REQ-023 With ZERO_FAST=1, a divisor-zero request SHALL behave as follows:
  - Div_Stall high in cycle T only;
  - Div_Done high at T+1.
REQ-024 Flush=1 in any state SHALL cause the following:
  - force Div_Stall=0 and Div_Done=0 in that cycle;
  - return to IDLE at the next edge;
  - leave Div_Lo/Div_Hi unchanged.
REQ-025 Flush has priority over EXE_DivReq in the same cycle; no request is accepted.
REQ-026 Back-to-back divides SHALL be handled as follows:
  - the DONE cycle consumes the current instruction;
  - a new request is accepted in the following IDLE cycle with no extra bubble.
REQ-027 Div_Lo/Div_Hi SHALL hold the last completed result until the next DONE.

Reset
REQ-028 With rst=0 at a rising edge, the block SHALL:
  - enter IDLE;
  - clear the counter, internal operand/partial registers, Div_Lo and Div_Hi to 0.
REQ-029 While rst=0, Div_Stall and Div_Done SHALL be 0 regardless of inputs.
REQ-030 Reset mid-BUSY SHALL abandon the operation; no Div_Done is produced afterward.

Verification
REQ-031 DIVU 100/7 at T:
  - Div_Stall high T..T+32;
  - Div_Done at T+33 with Lo=14, Hi=2.
REQ-032 DIV -7/2 (0xFFFFFFF9, 2) -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 7/-2 -> Lo=0xFFFFFFFD, Hi=1.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0; DIVU of the same operands -> Lo=0, Hi=0x80000000.
REQ-034 DIVU 0x1234/0 with ZERO_FAST=1:
  - Div_Stall high only at T;
  - Div_Done at T+1 with Lo=0xFFFFFFFF, Hi=0x1234.
  - With ZERO_FAST=0: Div_Done at T+33 with the same values.
REQ-035 Flush at BUSY counter==10:
  - Div_Stall=0 that cycle, IDLE next cycle;
  - no Div_Done, Lo/Hi keep the prior result;
  - a subsequent DIVU 9/3 completes with Lo=3, Hi=0.
REQ-036 rst=0 at BUSY counter==5:
  - all outputs 0 at the next edge;
  - no Div_Done within 40 cycles while EXE_DivReq=0.

Source files
------------

// File: rtl/div_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl_if
// Handshake/data bundle between the EXE stage and the iterative divider
// sequencer.
//   master : EXE side. Drives the request, operands and flush, and receives
//            stall/done/results.
//   slave  : divider sequencer. Receives the request and drives stall/done and
//            the HI/LO results.
// Signals:
//   EXE_DivReq    EXE holds a valid DIV/DIVU
//   EXE_DivSigned 1 = DIV (signed), 0 = DIVU
//   EXE_BusA      dividend (forwarded)
//   EXE_BusB      divisor (forwarded)
//   Flush         abort from exception/ERET commit in MEM
//   Div_Stall     hold PC, IF/ID, ID/EXE; bubble EXE/MEM
//   Div_Done      one-cycle pulse, results valid
//   Div_Lo        quotient
//   Div_Hi        remainder
// -----------------------------------------------------------------------------
interface div_seq_ctrl_if;
    logic        EXE_DivReq;
    logic        EXE_DivSigned;
    logic [31:0] EXE_BusA;
    logic [31:0] EXE_BusB;
    logic        Flush;
    logic        Div_Stall;
    logic        Div_Done;
    logic [31:0] Div_Lo;
    logic [31:0] Div_Hi;

    modport master (
        output EXE_DivReq, EXE_DivSigned, EXE_BusA, EXE_BusB, Flush,
        input  Div_Stall, Div_Done, Div_Lo, Div_Hi
    );

    modport slave (
        input  EXE_DivReq, EXE_DivSigned, EXE_BusA, EXE_BusB, Flush,
        output Div_Stall, Div_Done, Div_Lo, Div_Hi
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Sequencer for the 32-bit iterative (restoring) divider serving DIV/DIVU in
// EXE. Stalls the front of the pipeline while a divide runs and delivers the
// quotient (LO) and remainder (HI).
// Parameters:
//   ZERO_FAST  1 = divisor-zero requests complete without iterating,
//              0 = divisor-zero requests run the full 32 iterations.
// Ports:
//   clk  pipeline clock, rising edge
//   rst  synchronous reset, active low
//   bus  div_seq_ctrl_if.slave (request, operands, flush, stall, done, HI/LO)
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [4:0]  cnt_reg;
    // dvd_reg starts as |A| and shifts left one bit per step while quotient
    // bits enter at the bottom, so it holds the quotient after 32 steps.
    logic [31:0] dvd_reg;
    logic [31:0] dvs_reg;
    logic [31:0] rem_reg;
    logic        q_sign_reg;
    logic        r_sign_reg;
    logic        zero_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_reg;

    logic        accept;
    logic        b_zero;
    logic        fast_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] dvd_step;
    logic [31:0] lo_res;
    logic [31:0] hi_res;
    logic        div_stall;
    logic        div_done;

    // ---------------------------------------------------------------- operands
    assign b_zero    = (bus.EXE_BusB == 32'd0);
    assign fast_zero = ZERO_FAST && b_zero;
    assign abs_a     = (bus.EXE_DivSigned && bus.EXE_BusA[31]) ? -bus.EXE_BusA : bus.EXE_BusA;
    assign abs_b     = (bus.EXE_DivSigned && bus.EXE_BusB[31]) ? -bus.EXE_BusB : bus.EXE_BusB;
    assign accept    = (state_reg == IDLE) && bus.EXE_DivReq && !bus.Flush;

    // ------------------------------------------------- restoring divide step
    // A 33-bit trial subtraction: bit 32 of the difference is the borrow, so
    // a clear bit 32 means the divisor fits and the quotient bit is 1.
    assign rem_shift = {rem_reg, dvd_reg[31]};
    assign diff      = rem_shift - {1'b0, dvs_reg};
    assign q_bit     = ~diff[32];
    assign rem_step  = q_bit ? diff[31:0] : rem_shift[31:0];
    assign dvd_step  = {dvd_reg[30:0], q_bit};

    // --------------------------------------------------------- sign correction
    // A zero divisor always yields an all-ones quotient. The remainder path
    // needs no special case: rem_reg ends up as |A| (iterated or loaded
    // directly) and the remainder sign turns it back into the original A.
    assign lo_res = zero_reg   ? 32'hFFFF_FFFF : (q_sign_reg ? -dvd_reg : dvd_reg);
    assign hi_res = r_sign_reg ? -rem_reg : rem_reg;

    // ------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = fast_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.Flush) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        div_stall = 1'b0;
        div_done  = 1'b0;
        if (rst && !bus.Flush) begin
            case (state_reg)
                IDLE:    div_stall = bus.EXE_DivReq;
                BUSY:    div_stall = 1'b1;
                DONE:    div_done  = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.Div_Stall = div_stall;
    assign bus.Div_Done  = div_done;
    // Results are presented during the Div_Done cycle itself and are captured
    // into lo_reg/hi_reg at the end of it; a flushed DONE leaves them alone.
    assign bus.Div_Lo    = div_done ? lo_res : lo_reg;
    assign bus.Div_Hi    = div_done ? hi_res : hi_reg;

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 5'd0;
            dvd_reg    <= 32'd0;
            dvs_reg    <= 32'd0;
            rem_reg    <= 32'd0;
            q_sign_reg <= 1'b0;
            r_sign_reg <= 1'b0;
            zero_reg   <= 1'b0;
            lo_reg     <= 32'd0;
            hi_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dvd_reg    <= abs_a;
                        dvs_reg    <= abs_b;
                        // The fast zero path skips iteration, so preload the
                        // value the iterations would have left behind.
                        rem_reg    <= fast_zero ? abs_a : 32'd0;
                        q_sign_reg <= bus.EXE_DivSigned & (bus.EXE_BusA[31] ^ bus.EXE_BusB[31]);
                        r_sign_reg <= bus.EXE_DivSigned & bus.EXE_BusA[31];
                        zero_reg   <= b_zero;
                        cnt_reg    <= 5'd0;
                    end
                end
                BUSY: begin
                    if (!bus.Flush) begin
                        dvd_reg <= dvd_step;
                        rem_reg <= rem_step;
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                DONE: begin
                    if (!bus.Flush) begin
                        lo_reg <= lo_res;
                        hi_reg <= hi_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
// Drives two sequencers (ZERO_FAST=0 and ZERO_FAST=1) with identical stimulus:
// a table of divide vectors with hand-computed results and latencies, then
// hand-written sequences for back-to-back divides, flush mid-divide, flush vs
// request priority, and reset mid-divide.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl_if if0 ();
    div_seq_ctrl_if if1 ();

    assign if0.EXE_DivReq    = req;
    assign if0.EXE_DivSigned = sgn;
    assign if0.EXE_BusA      = a;
    assign if0.EXE_BusB      = b;
    assign if0.Flush         = flush;
    assign if1.EXE_DivReq    = req;
    assign if1.EXE_DivSigned = sgn;
    assign if1.EXE_BusA      = a;
    assign if1.EXE_BusB      = b;
    assign if1.Flush         = flush;

    div_seq_ctrl #(.ZERO_FAST(1'b0)) dut_slow (.clk(clk), .rst(rst), .bus(if0.slave));
    div_seq_ctrl #(.ZERO_FAST(1'b1)) dut_fast (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat_slow;
        int          lat_fast;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Precondition: called just after a rising edge. Request is presented for
    // one cycle (T), then operands are scrambled to prove they are not re-read.
    task automatic run_vec(input vec_t v, input int idx);
        int          done_cyc[2];
        int          done_cnt[2];
        int          stall_cnt[2];
        logic [31:0] lo_at[2];
        logic [31:0] hi_at[2];
        logic        st[2];
        logic        dn[2];
        logic [31:0] lo_now[2];
        logic [31:0] hi_now[2];
        int          lat[2];
        for (int k = 0; k < 2; k++) begin
            done_cyc[k] = -1; done_cnt[k] = 0; stall_cnt[k] = 0;
            lo_at[k] = '0; hi_at[k] = '0;
        end
        lat[0] = v.lat_slow;
        lat[1] = v.lat_fast;
        req = 1'b1; sgn = v.sgn; a = v.a; b = v.b;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            st[0] = if0.Div_Stall; dn[0] = if0.Div_Done; lo_now[0] = if0.Div_Lo; hi_now[0] = if0.Div_Hi;
            st[1] = if1.Div_Stall; dn[1] = if1.Div_Done; lo_now[1] = if1.Div_Lo; hi_now[1] = if1.Div_Hi;
            for (int k = 0; k < 2; k++) begin
                if (st[k]) stall_cnt[k]++;
                if (dn[k]) begin
                    done_cnt[k]++;
                    if (done_cyc[k] < 0) begin
                        done_cyc[k] = cyc; lo_at[k] = lo_now[k]; hi_at[k] = hi_now[k];
                    end
                end
            end
            @(posedge clk); #1;
            if (cyc == 0) begin
                req = 1'b0; sgn = ~v.sgn; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("v%0d_d%0d_done_cycle", idx, k), done_cyc[k], lat[k]);
            chk($sformatf("v%0d_d%0d_done_count", idx, k), done_cnt[k], 1);
            chk($sformatf("v%0d_d%0d_stall_cycles", idx, k), stall_cnt[k], lat[k]);
            chk($sformatf("v%0d_d%0d_lo", idx, k), lo_at[k], v.lo);
            chk($sformatf("v%0d_d%0d_hi", idx, k), hi_at[k], v.hi);
        end
        chk($sformatf("v%0d_d0_lo_held", idx), if0.Div_Lo, v.lo);
        chk($sformatf("v%0d_d1_hi_held", idx), if1.Div_Hi, v.hi);
        $display("vec %0d signed=%0d a=%h b=%h lo=%h hi=%h done@%0d/%0d",
                 idx, v.sgn, v.a, v.b, lo_at[1], hi_at[1], done_cyc[0], done_cyc[1]);
    endtask

    // Counts Div_Done pulses and stall cycles on both DUTs over n cycles.
    task automatic quiet_window(input int n, output int dones, output int stalls);
        dones = 0; stalls = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (if0.Div_Done) dones++;
            if (if1.Div_Done) dones++;
            if (if0.Div_Stall) stalls++;
            if (if1.Div_Stall) stalls++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int d1, d2, dones, stalls;
        logic s_done, s_after;
        logic [31:0] lo1, hi1, lo2, hi2;

        //            sgn   a              b              lo             hi             slow fast
        vecs[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  33, 33};
        vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         33, 33};
        vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         33, 33};
        vecs[4] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  33, 33};
        vecs[5] = '{1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      33, 1};
        vecs[6] = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  33, 1};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         33, 33};
        vecs[8] = '{1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         33, 33};
        vecs[9] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  33, 33};

        // ---------------------------------------------------------- reset
        rst = 1'b0; req = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_d0", if0.Div_Stall, 1'b0);
        chk("rst_stall_d1", if1.Div_Stall, 1'b0);
        chk("rst_done_d1", if1.Div_Done, 1'b0);
        chk("rst_lo_d1", if1.Div_Lo, 32'd0);
        chk("rst_hi_d0", if0.Div_Hi, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;

        // ---------------------------------------------------------- table
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // ---------------------------------------------------------- back-to-back
        // EXE holds the request until Done; the next divide is presented right
        // after the Done cycle and must be accepted with no bubble.
        d1 = -1; d2 = -1; s_done = 1'b1; s_after = 1'b0;
        lo1 = '0; hi1 = '0; lo2 = '0; hi2 = '0;
        req = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (d1 >= 0 && cyc == d1 + 1) s_after = if1.Div_Stall;
            if (if1.Div_Done) begin
                if (d1 < 0) begin
                    d1 = cyc; lo1 = if1.Div_Lo; hi1 = if1.Div_Hi; s_done = if1.Div_Stall;
                end else if (d2 < 0) begin
                    d2 = cyc; lo2 = if1.Div_Lo; hi2 = if1.Div_Hi;
                end
            end
            @(posedge clk); #1;
            if (cyc == d1) begin a = 32'd50; b = 32'd6; end
            if (d2 >= 0 && cyc == d2) req = 1'b0;
        end
        req = 1'b0;
        chk("b2b_first_done", d1, 33);
        chk("b2b_stall_in_done", s_done, 1'b0);
        chk("b2b_stall_next", s_after, 1'b1);
        chk("b2b_second_done", d2, 67);
        chk("b2b_lo1", lo1, 32'd14);
        chk("b2b_hi1", hi1, 32'd2);
        chk("b2b_lo2", lo2, 32'd8);
        chk("b2b_hi2", hi2, 32'd2);
        chk("b2b_lo_d0", if0.Div_Lo, 32'd8);
        $display("b2b done@%0d,%0d lo=%h,%h hi=%h,%h", d1, d2, lo1, lo2, hi1, hi2);

        // ---------------------------------------------------------- flush at counter 10
        req = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        req = 1'b0;                       // T+1, counter 0
        repeat (10) @(posedge clk);
        #1;                               // T+11, counter 10
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_d0", if0.Div_Stall, 1'b0);
        chk("flush_stall_d1", if1.Div_Stall, 1'b0);
        chk("flush_done_d1", if1.Div_Done, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", if1.Div_Stall, 1'b0);
        // Flush beats a simultaneous request.
        @(posedge clk); #1;
        req = 1'b1; a = 32'd77; b = 32'd5; flush = 1'b1;
        @(negedge clk);
        chk("flushreq_stall", if1.Div_Stall, 1'b0);
        @(posedge clk); #1;
        req = 1'b0; flush = 1'b0;
        quiet_window(40, dones, stalls);
        chk("flush_no_done", dones, 0);
        chk("flush_no_stall", stalls, 0);
        chk("flush_lo_kept", if1.Div_Lo, 32'd8);
        chk("flush_hi_kept", if0.Div_Hi, 32'd2);
        $display("flush dones=%0d stalls=%0d lo=%h hi=%h", dones, stalls, if1.Div_Lo, if1.Div_Hi);
        begin
            vec_t v93;
            v93 = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 33};
            run_vec(v93, 10);
        end

        // ---------------------------------------------------------- reset at counter 5
        req = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;                       // T+1, counter 0
        repeat (5) @(posedge clk);
        #1;                               // T+6, counter 5
        rst = 1'b0;
        @(negedge clk);
        chk("rstbusy_stall", if1.Div_Stall, 1'b0);
        chk("rstbusy_done", if0.Div_Done, 1'b0);
        @(posedge clk); #1;
        chk("rstbusy_lo", if1.Div_Lo, 32'd0);
        chk("rstbusy_hi", if1.Div_Hi, 32'd0);
        chk("rstbusy_lo_d0", if0.Div_Lo, 32'd0);
        rst = 1'b1;
        quiet_window(40, dones, stalls);
        chk("rstbusy_no_done", dones, 0);
        chk("rstbusy_no_stall", stalls, 0);
        $display("reset-mid-busy dones=%0d stalls=%0d", dones, stalls);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
